// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: sequences loads/stores as req/ack bus transactions,
// stalls the pipeline while outstanding, and handles lane steering and fault reporting.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [63:0] addr,
   input  logic [63:0] store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [63:0] dmem_rdata,
   output logic        mem_stall,
   output logic [63:0] load_data,
   output logic        load_valid,
   output logic        misaligned_exc,
   output logic        bus_err,
   output logic [63:0] exc_addr
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e            state_q, state_d;
   logic [63:0]       addr_q, addr_d;
   logic              we_q, we_d;
   logic [7:0]        be_q, be_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [2:0]        off_q, off_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [63:0]       load_data_q, load_data_d;
   logic              load_valid_q, load_valid_d;
   logic              mis_q, mis_d;
   logic              bus_err_q, bus_err_d;
   logic [63:0]       exc_addr_q, exc_addr_d;

   logic              access;
   logic [2:0]        off;
   logic              misaligned;
   logic [7:0]        be_new;
   logic [63:0]       rshift;
   logic [63:0]       extracted;

   assign access = mem_read | mem_write;
   assign off    = addr[2:0];

   // funct3[1:0] encodes the size for signed, unsigned and the 111 alias alike
   always_comb begin
      misaligned = 1'b0;
      be_new     = 8'h00;
      unique case (funct3[1:0])
         2'b00: begin misaligned = 1'b0;           be_new = 8'h01 << off; end
         2'b01: begin misaligned = off[0];         be_new = 8'h03 << off; end
         2'b10: begin misaligned = |off[1:0];      be_new = 8'h0F << off; end
         2'b11: begin misaligned = |off;           be_new = 8'hFF;        end
         default: ;
      endcase
      if (!mem_write) be_new = 8'h00;
   end

   always_comb begin
      rshift = dmem_rdata >> {off_q, 3'b000};
      unique case (funct3_q)
         3'b000:  extracted = {{56{rshift[7]}},  rshift[7:0]};
         3'b001:  extracted = {{48{rshift[15]}}, rshift[15:0]};
         3'b010:  extracted = {{32{rshift[31]}}, rshift[31:0]};
         3'b100:  extracted = {56'd0, rshift[7:0]};
         3'b101:  extracted = {48'd0, rshift[15:0]};
         3'b110:  extracted = {32'd0, rshift[31:0]};
         default: extracted = rshift;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      cnt_d        = cnt_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      mis_d        = 1'b0;
      bus_err_d    = 1'b0;
      exc_addr_d   = exc_addr_q;
      unique case (state_q)
         StIdle: begin
            if (access && !misaligned) begin
               state_d  = StAccess;
               addr_d   = {addr[63:3], 3'b000};
               we_d     = mem_write;
               be_d     = be_new;
               wdata_d  = store_data << {off, 3'b000};
               funct3_d = funct3;
               off_d    = off;
               cnt_d    = '0;
            end else if (access) begin
               mis_d      = 1'b1;
               exc_addr_d = addr;
            end
         end
         StAccess: begin
            // ack wins over a timeout reached in the same cycle
            if (dmem_ack) begin
               state_d = StDone;
               if (!we_q) begin
                  load_data_d  = extracted;
                  load_valid_d = 1'b1;
               end
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               state_d    = StDone;
               bus_err_d  = 1'b1;
               exc_addr_d = {addr_q[63:3], off_q};
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         we_q         <= 1'b0;
         be_q         <= '0;
         wdata_q      <= '0;
         funct3_q     <= '0;
         off_q        <= '0;
         cnt_q        <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         mis_q        <= 1'b0;
         bus_err_q    <= 1'b0;
         exc_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         cnt_q        <= cnt_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         mis_q        <= mis_d;
         bus_err_q    <= bus_err_d;
         exc_addr_q   <= exc_addr_d;
      end
   end

   assign dmem_req       = (state_q == StAccess);
   assign dmem_we        = we_q & dmem_req;
   assign dmem_addr      = addr_q;
   assign dmem_wdata     = wdata_q;
   assign dmem_be        = be_q;
   assign load_data      = load_data_q;
   assign load_valid     = load_valid_q;
   assign misaligned_exc = mis_q;
   assign bus_err        = bus_err_q;
   assign exc_addr       = exc_addr_q;
   // gated by reset_n so the stall cannot leak while the block is held in reset
   assign mem_stall      = reset_n &
                           (((state_q == StIdle) && access && !misaligned) ||
                            (state_q == StAccess));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, misalignment, timeout, reset, back-to-back.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [63:0] addr, store_data;
   logic        dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_be;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic        mem_stall;
   logic [63:0] load_data;
   logic        load_valid, misaligned_exc, bus_err;
   logic [63:0] exc_addr;

   int total = 0;
   int bad   = 0;

   mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .funct3         (funct3),
      .addr           (addr),
      .store_data     (store_data),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_be        (dmem_be),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata),
      .mem_stall      (mem_stall),
      .load_data      (load_data),
      .load_valid     (load_valid),
      .misaligned_exc (misaligned_exc),
      .bus_err        (bus_err),
      .exc_addr       (exc_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] sd);
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
   endtask

   initial begin
      reset_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      req(1'b1, 1'b0, 3'b011, 64'h40, 64'h0);
      smp();
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_be", dmem_be, 0);
      chk("rst_ldata", load_data, 0);
      chk("rst_exc", exc_addr, 0);
      chk("rst_flags", {load_valid, misaligned_exc, bus_err}, 0);
      cyc();
      req(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
      reset_n = 1'b1;
      cyc();

      // SW 0x1004, ack on 2nd ACCESS cycle
      req(1'b0, 1'b1, 3'b010, 64'h1004, 64'hDEADBEEF);
      smp(); chk("sw_idle_stall", mem_stall, 1); chk("sw_idle_req", dmem_req, 0);
      cyc();
      smp();
      chk("sw_req", dmem_req, 1); chk("sw_we", dmem_we, 1);
      chk("sw_addr", dmem_addr, 64'h1000); chk("sw_be", dmem_be, 8'hF0);
      chk("sw_wdata", dmem_wdata, 64'hDEADBEEF_00000000); chk("sw_stall1", mem_stall, 1);
      cyc(); dmem_ack = 1'b1;
      smp(); chk("sw_stall2", mem_stall, 1); chk("sw_addr_hold", dmem_addr, 64'h1000);
      cyc(); dmem_ack = 1'b0;
      smp(); chk("sw_done_stall", mem_stall, 0); chk("sw_done_req", dmem_req, 0);
      chk("sw_done_lv", load_valid, 0);
      cyc(); req(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);

      // LB / LBU 0x2003, immediate ack
      for (int u = 0; u < 2; u++) begin
         req(1'b1, 1'b0, (u == 0) ? 3'b000 : 3'b100, 64'h2003, 64'h0);
         smp(); chk("lb_idle_stall", mem_stall, 1);
         cyc(); dmem_ack = 1'b1; dmem_rdata = 64'h00000000_80000000;
         smp(); chk("lb_req", dmem_req, 1); chk("lb_be", dmem_be, 0); chk("lb_we", dmem_we, 0);
         cyc(); dmem_ack = 1'b0; dmem_rdata = '0;
         smp(); chk("lb_lv", load_valid, 1); chk("lb_stall_done", mem_stall, 0);
         chk("lb_data", load_data, (u == 0) ? 64'hFFFFFFFF_FFFFFF80 : 64'h80);
         cyc(); req(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
         smp(); chk("lb_lv_end", load_valid, 0);
         chk("lb_hold", load_data, (u == 0) ? 64'hFFFFFFFF_FFFFFF80 : 64'h80);
         cyc();
      end

      // LW misaligned at 0x1002
      req(1'b1, 1'b0, 3'b010, 64'h1002, 64'h0);
      smp(); chk("mis_stall", mem_stall, 0); chk("mis_req", dmem_req, 0);
      chk("mis_early", misaligned_exc, 0);
      cyc(); req(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
      smp(); chk("mis_exc", misaligned_exc, 1); chk("mis_addr", exc_addr, 64'h1002);
      chk("mis_req2", dmem_req, 0);
      cyc();
      smp(); chk("mis_pulse_end", misaligned_exc, 0); chk("mis_addr_hold", exc_addr, 64'h1002);
      cyc();

      // LD 0x3000 timeout with TIMEOUT_CYCLES=4
      req(1'b1, 1'b0, 3'b011, 64'h3000, 64'h0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         smp(); chk("to_req", dmem_req, 1); chk("to_berr_early", bus_err, 0);
         cyc();
      end
      smp(); chk("to_berr", bus_err, 1); chk("to_exc", exc_addr, 64'h3000);
      chk("to_lv", load_valid, 0); chk("to_req_done", dmem_req, 0);
      cyc(); req(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
      smp(); chk("to_berr_end", bus_err, 0); chk("to_idle_req", dmem_req, 0);
      cyc();

      // LD 0x3008 with ack on the limit cycle: success, no bus_err
      req(1'b1, 1'b0, 3'b011, 64'h3008, 64'h0);
      cyc(); cyc(); cyc(); cyc();
      dmem_ack = 1'b1; dmem_rdata = 64'h11223344_55667788;
      smp(); chk("lim_req", dmem_req, 1);
      cyc(); dmem_ack = 1'b0;
      smp(); chk("lim_berr", bus_err, 0); chk("lim_lv", load_valid, 1);
      chk("lim_data", load_data, 64'h11223344_55667788); chk("lim_exc", exc_addr, 64'h3000);
      cyc(); req(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
      cyc();

      // SD interrupted by reset mid-ACCESS
      req(1'b0, 1'b1, 3'b011, 64'h8, 64'h0123456789ABCDEF);
      cyc();
      smp(); chk("sd_req", dmem_req, 1); chk("sd_be", dmem_be, 8'hFF);
      #1 reset_n = 1'b0;
      #1;
      chk("sd_rst_req", dmem_req, 0); chk("sd_rst_stall", mem_stall, 0);
      chk("sd_rst_wdata", dmem_wdata, 0); chk("sd_rst_ldata", load_data, 0);
      chk("sd_rst_exc", exc_addr, 0);
      cyc();
      smp(); chk("sd_rst_hold_stall", mem_stall, 0);
      cyc(); reset_n = 1'b1;
      req(1'b1, 1'b0, 3'b101, 64'h10, 64'h0);
      smp(); chk("lhu_stall", mem_stall, 1);
      cyc(); dmem_ack = 1'b1; dmem_rdata = 64'hBEEF0000_0000FFFE;
      smp(); chk("lhu_addr", dmem_addr, 64'h10);
      cyc(); dmem_ack = 1'b0;
      smp(); chk("lhu_data", load_data, 64'hFFFE); chk("lhu_lv", load_valid, 1);
      cyc(); req(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
      cyc();

      // Back-to-back SB at 0x7 then 0x0; ack held high to catch any re-issue
      req(1'b0, 1'b1, 3'b000, 64'h7, 64'hA5);
      dmem_ack = 1'b1;
      cyc();
      smp(); chk("sb1_req", dmem_req, 1); chk("sb1_be", dmem_be, 8'h80);
      chk("sb1_wdata", dmem_wdata, 64'hA500000000000000);
      cyc();
      smp(); chk("sb1_done_req", dmem_req, 0); chk("sb1_done_stall", mem_stall, 0);
      cyc(); req(1'b0, 1'b1, 3'b000, 64'h0, 64'h5A);
      smp(); chk("sb2_idle_req", dmem_req, 0); chk("sb2_idle_stall", mem_stall, 1);
      cyc();
      smp(); chk("sb2_req", dmem_req, 1); chk("sb2_be", dmem_be, 8'h01);
      chk("sb2_wdata", dmem_wdata, 64'h5A);
      cyc();
      smp(); chk("sb2_done_req", dmem_req, 0);
      cyc(); req(1'b0, 1'b0, 3'b000, 64'h0, 64'h0); dmem_ack = 1'b0;
      smp(); chk("sb_end_req", dmem_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
